// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the 5-stage core and pipe_ctrl: stall requests and branch
// resolution in, stall vector, redirect, multi-cycle status and perf counters out.
interface pipe_ctrl_if;
    logic        req_if;
    logic        req_id;
    logic        mc_start;
    logic        req_mem;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_busy;
    logic        mc_done;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    logic [1:0]  state_dbg;

    // The core side drives requests; pipe_ctrl answers combinationally in the same cycle.
    modport master (
        output req_if, req_id, mc_start, req_mem, branch_taken, branch_target,
        input  stall, flush, new_pc, mc_busy, mc_done, stall_cycles, flush_count, state_dbg
    );
    modport slave (
        input  req_if, req_id, mc_start, req_mem, branch_taken, branch_target,
        output stall, flush, new_pc, mc_busy, mc_done, stall_cycles, flush_count, state_dbg
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall arbitration, multi-cycle EX sequencing and deferred branch redirect.
// Optional perf counters (stall_cycles, flush_count) are built only when STALL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 6
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MC   = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic [31:0]      new_pc_q;

    logic        mc_act;
    logic        mc_busy;
    logic        blocking;
    logic        flush;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        mc_done;

    // Stall arbitration and redirect; a flush always clears the stall vector.
    always_comb begin
        mc_act   = bus.mc_start && (state_q != MC);
        mc_busy  = (state_q == MC) || mc_act;
        blocking = bus.req_mem || mc_busy;
        flush    = 1'b0;
        flush_pc = new_pc_q;
        stall    = 6'b000000;
        if (!blocking) begin
            if (state_q == PEND) begin
                flush    = 1'b1;
                flush_pc = pend_pc_q;
            end else if (bus.branch_taken) begin
                flush    = 1'b1;
                flush_pc = bus.branch_target;
            end
        end
        if (flush)               stall = 6'b000000;
        else if (bus.req_mem)    stall = 6'b011111;
        else if (mc_busy)        stall = 6'b001111;
        else if (bus.req_id)     stall = 6'b000111;
        else if (bus.req_if)     stall = 6'b000011;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        mc_done   = 1'b0;
        case (state_q)
            RUN: begin
                if (mc_act && !bus.req_mem) begin
                    // mc_start beats a simultaneous branch, which then waits behind the op
                    state_d = MC;
                    cnt_d   = MC_LOAD;
                    pend_d  = bus.branch_taken;
                    if (bus.branch_taken) pend_pc_d = bus.branch_target;
                end else if (bus.branch_taken && blocking) begin
                    state_d   = PEND;
                    pend_pc_d = bus.branch_target;
                end
            end
            MC: begin
                if (bus.branch_taken && !pend_q) begin
                    pend_d    = 1'b1;
                    pend_pc_d = bus.branch_target;
                end
                if (!bus.req_mem) begin
                    if (cnt_q == CNT_ONE) begin
                        mc_done = 1'b1;
                        state_d = pend_d ? PEND : RUN;
                        pend_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            PEND: begin
                if (flush) begin
                    state_d = RUN;
                end else if (mc_act && !bus.req_mem) begin
                    state_d = MC;
                    cnt_d   = MC_LOAD;
                    pend_d  = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            new_pc_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            new_pc_q  <= flush_pc;
        end
    end

    // Outputs are forced quiet for the whole reset cycle, not just after it.
    assign bus.stall     = rst ? 6'b0  : stall;
    assign bus.flush     = rst ? 1'b0  : flush;
    assign bus.new_pc    = rst ? 32'b0 : flush_pc;
    assign bus.mc_busy   = rst ? 1'b0  : mc_busy;
    assign bus.mc_done   = rst ? 1'b0  : mc_done;
    assign bus.state_dbg = state_q;

`ifdef STALL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((stall != 6'b0) && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush && !(&flush_cnt_q))           flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign bus.stall_cycles = rst ? 32'b0 : stall_cnt_q;
    assign bus.flush_count  = rst ? 16'b0 : flush_cnt_q;
`else
    assign bus.stall_cycles = 32'b0;
    assign bus.flush_count  = 16'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl (MC_CYCLES=4): driver pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_pipe_ctrl;
  localparam int W = 89;
`ifdef STALL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;
  pipe_ctrl_if bus ();

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_sc = 0;
  logic [15:0] exp_fc = 0;

  pipe_ctrl #(.MC_CYCLES(4), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1;
    bus.req_if = 1'b0;
    bus.req_id = 1'b0;
    bus.mc_start = 1'b0;
    bus.req_mem = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'h0;
  end

  // driver
  task automatic step(input logic rst_v, input logic rif, input logic rid, input logic mcs,
                      input logic rmem, input logic bt, input logic [31:0] tgt,
                      input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                      input logic e_busy, input logic e_done);
    @(posedge clk);
    #1;
    rst = rst_v;
    bus.req_if = rif;
    bus.req_id = rid;
    bus.mc_start = mcs;
    bus.req_mem = rmem;
    bus.branch_taken = bt;
    bus.branch_target = tgt;
    if (rst_v) begin
      exp_sc = 0;
      exp_fc = 0;
    end
    exp_q.push_back({e_stall, e_flush, e_pc, e_busy, e_done,
                     PERF ? exp_sc : 32'h0, PERF ? exp_fc : 16'h0});
    if (!rst_v) begin
      if (e_stall != 6'b0) exp_sc = exp_sc + 1;
      if (e_flush) exp_fc = exp_fc + 1;
    end
  endtask

  task automatic idle(input logic [31:0] e_pc);
    step(0, 0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, e_pc, 0, 0);
  endtask

  // scoreboard monitor
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall",        {26'b0, bus.stall},    {26'b0, e[88:83]});
      chk("flush",        {31'b0, bus.flush},    {31'b0, e[82]});
      chk("new_pc",       bus.new_pc,            e[81:50]);
      chk("mc_busy",      {31'b0, bus.mc_busy},  {31'b0, e[49]});
      chk("mc_done",      {31'b0, bus.mc_done},  {31'b0, e[48]});
      chk("stall_cycles", bus.stall_cycles,      e[47:16]);
      chk("flush_count",  {16'b0, bus.flush_count}, {16'b0, e[15:0]});
    end
  end

  initial begin
    // reset: outputs quiet even with requests asserted
    step(1, 0, 0, 0, 1, 0, 32'h0,  6'b000000, 0, 32'h0, 0, 0);
    step(1, 0, 0, 1, 0, 1, 32'h55, 6'b000000, 0, 32'h0, 0, 0);
    idle(32'h0);
    // single-level stall requests and priority
    step(0, 0, 1, 0, 0, 0, 32'h0, 6'b000111, 0, 32'h0, 0, 0);
    idle(32'h0);
    step(0, 1, 0, 0, 0, 0, 32'h0, 6'b000011, 0, 32'h0, 0, 0);
    idle(32'h0);
    step(0, 1, 1, 0, 1, 0, 32'h0, 6'b011111, 0, 32'h0, 0, 0);
    idle(32'h0);
    // multi-cycle op, second mc_start ignored, req_id inside MC
    step(0, 0, 0, 1, 0, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 1);
    idle(32'h0);
    // multi-cycle op frozen by req_mem for two cycles
    step(0, 0, 0, 1, 0, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 32'h0, 6'b011111, 0, 32'h0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 32'h0, 6'b011111, 0, 32'h0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 1);
    idle(32'h0);
    // immediate branch overrides req_id
    step(0, 0, 1, 0, 0, 1, 32'h100, 6'b000000, 1, 32'h100, 0, 0);
    idle(32'h100);
    // branch deferred behind req_mem, second branch ignored
    step(0, 0, 0, 0, 1, 1, 32'h200, 6'b011111, 0, 32'h100, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h300, 6'b011111, 0, 32'h100, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h0,   6'b011111, 0, 32'h100, 0, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0,   6'b000000, 1, 32'h200, 0, 0);
    idle(32'h200);
    // mc_start and branch together: branch waits for the op
    step(0, 0, 0, 1, 0, 1, 32'h400, 6'b001111, 0, 32'h200, 1, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h200, 1, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h200, 1, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h200, 1, 1);
    step(0, 1, 0, 0, 0, 0, 32'h0,   6'b000000, 1, 32'h400, 0, 0);
    idle(32'h400);
    // branch arriving mid-op
    step(0, 0, 0, 1, 0, 0, 32'h0,   6'b001111, 0, 32'h400, 1, 0);
    step(0, 0, 0, 0, 0, 1, 32'h500, 6'b001111, 0, 32'h400, 1, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h400, 1, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h400, 1, 1);
    step(0, 0, 0, 0, 0, 0, 32'h0,   6'b000000, 1, 32'h500, 0, 0);
    idle(32'h500);
    idle(32'h500);
    // reset while in MC with a pending branch
    step(0, 0, 0, 1, 0, 0, 32'h0,   6'b001111, 0, 32'h500, 1, 0);
    step(0, 0, 0, 0, 0, 1, 32'h600, 6'b001111, 0, 32'h500, 1, 0);
    step(1, 0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0);
    idle(32'h0);
    idle(32'h0);
    idle(32'h0);
    idle(32'h0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
